// File: rtl/as_arb_pkg.sv
// rtl/as_arb_pkg.sv - shared state encoding, opcodes and saturation helpers for as_arb
package as_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Callers truncate to their own width: 0 followed by width-1 ones.
    function automatic logic [63:0] sat_max(input int unsigned width);
        sat_max = (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // 1 followed by width-1 zeros.
    function automatic logic [63:0] sat_min(input int unsigned width);
        sat_min = 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/as_arb_if.sv
// rtl/as_arb_if.sv - request/response bundle between requesters and the as_arb arbiter
interface as_arb_if #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_sel;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_s;
    logic                   res_o;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    modport master (
        output req_valid, req_sel, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_s, res_o, res_id, busy
    );

    modport slave (
        input  req_valid, req_sel, req_a, req_b, res_ready,
        output req_ready, res_valid, res_s, res_o, res_id, busy
    );
endinterface

// File: rtl/as_arb_rr_pick.sv
// rtl/as_arb_rr_pick.sv - combinational round-robin picker: first valid at or after ptr, wrapping
module as_arb_rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id,
    output logic             any_valid
);

    // One extra bit so ptr + offset cannot overflow before the modulo wrap.
    logic [ID_W:0] cand;

    always_comb begin
        grant     = '0;
        id        = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!any_valid && valid[cand[ID_W-1:0]]) begin
                any_valid               = 1'b1;
                grant[cand[ID_W-1:0]]   = 1'b1;
                id                      = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/as_arb.sv
// rtl/as_arb.sv - round-robin arbiter over a shared add/sub datapath; AS_ARB_SAT_EN enables saturation
module as_arb
    import as_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic     clk,
    input  logic     rst_n,
    as_arb_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EXEC = EXEC;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;

    logic             op_sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [ID_W-1:0]  op_id;

    logic             res_valid_q;
    logic [WIDTH-1:0] res_s_q;
    logic             res_o_q;
    logic [ID_W-1:0]  res_id_q;

    as_arb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .id        (pick_id),
        .any_valid (pick_any)
    );

    // Gated by rst_n so no accept is advertised while reset is held.
    assign bus.req_ready = (rst_n && state == ST_IDLE) ? pick_grant : '0;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_s     = res_s_q;
    assign bus.res_o     = res_o_q;
    assign bus.res_id    = res_id_q;

    logic             cin;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] low_sum;
    logic [1:0]       msb_sum;
    logic [WIDTH-1:0] dp_s;
    logic [WIDTH-1:0] dp_s_final;
    logic             dp_o;

    // Low bits and MSB are summed separately to expose the carry into the MSB.
    always_comb begin
        cin        = (op_sel == OP_SUB);
        b_eff      = cin ? ~op_b : op_b;
        low_sum    = {1'b0, op_a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + WIDTH'(cin);
        msb_sum    = {1'b0, op_a[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, low_sum[WIDTH-1]};
        dp_s       = {msb_sum[0], low_sum[WIDTH-2:0]};
        dp_o       = low_sum[WIDTH-1] ^ msb_sum[1];
`ifdef AS_ARB_SAT_EN
        if (dp_o) begin
            dp_s_final = op_a[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
        end else begin
            dp_s_final = dp_s;
        end
`else
        dp_s_final = dp_s;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            op_sel      <= OP_ADD;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            res_valid_q <= 1'b0;
            res_s_q     <= '0;
            res_o_q     <= 1'b0;
            res_id_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        op_id  <= pick_id;
                        op_sel <= bus.req_sel[pick_id];
                        op_a   <= bus.req_a[int'(pick_id)*WIDTH +: WIDTH];
                        op_b   <= bus.req_b[int'(pick_id)*WIDTH +: WIDTH];
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_s_q     <= dp_s_final;
                    res_o_q     <= dp_o;
                    res_id_q    <= op_id;
                    res_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        rr_ptr      <= (res_id_q == ID_W'(N_REQ-1)) ? '0 : res_id_q + ID_W'(1);
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_as_arb.sv
// tb/tb_as_arb.sv - randomized self-checking bench for as_arb against a behavioural model
module tb_as_arb;

    localparam int WIDTH = 4;
    localparam int N_REQ = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    as_arb_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    as_arb #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;
    int ptr_m  = 0;

    // Signed integer arithmetic, then range check for overflow.
    task automatic model(input logic sel, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] s, output logic o);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r  = sel ? sa - sb : sa + sb;
        o  = (r > 7) || (r < -8);
        s  = 4'(r);
`ifdef AS_ARB_SAT_EN
        if (o) s = (sa < 0) ? 4'b1000 : 4'b0111;
`endif
    endtask

    function automatic int pick_model(input logic [1:0] mask);
        int idx;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (ptr_m + k) % N_REQ;
            if (mask[idx]) return idx;
        end
        return 0;
    endfunction

    // Entered and left at posedge+1 with the arbiter idle; res_ready held high.
    task automatic run_op(input logic [1:0] mask, input logic [1:0] sel, input logic [7:0] a,
                          input logic [7:0] b, output logic [1:0] rdy, output logic [3:0] s,
                          output logic o, output logic id, output int lat);
        bus.req_valid = mask;
        bus.req_sel   = sel;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.res_ready = 1'b1;
        #1 rdy = bus.req_ready;
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_sel   = 2'($urandom);
        bus.req_a     = 8'($urandom);
        bus.req_b     = 8'($urandom);
        lat = 1;
        while (!bus.res_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        s  = bus.res_s;
        o  = bus.res_o;
        id = bus.res_id;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 2'b11;
        bus.res_ready = 1'b1;
        #2;
        total++;
        if ({bus.req_ready, bus.res_valid, bus.busy, bus.res_s, bus.res_o, bus.res_id} !== 10'd0)
            $display("FAIL reset_outputs got rdy=%b v=%b busy=%b s=%h o=%b id=%b want all 0",
                     bus.req_ready, bus.res_valid, bus.busy, bus.res_s, bus.res_o, bus.res_id);
        else passed++;
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_directed();
        int         t_idx [4] = '{0, 1, 0, 1};
        logic       t_sel [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] t_a   [4] = '{4'd3, 4'b0111, 4'b1000, 4'd2};
        logic [3:0] t_b   [4] = '{4'd4, 4'b0001, 4'b0001, 4'd5};
        logic [1:0] mask, sel, rdy, exp_rdy;
        logic [7:0] a, b;
        logic [3:0] s, es;
        logic       o, eo, id;
        int         g, lat;
        for (int i = 0; i < 4; i++) begin
            g = t_idx[i];
            mask = '0;            mask[g] = 1'b1;
            sel  = 2'($urandom);  sel[g]  = t_sel[i];
            a    = 8'($urandom);  a[g*4 +: 4] = t_a[i];
            b    = 8'($urandom);  b[g*4 +: 4] = t_b[i];
            exp_rdy = mask;
            model(t_sel[i], t_a[i], t_b[i], es, eo);
            run_op(mask, sel, a, b, rdy, s, o, id, lat);
            total++; if (rdy !== exp_rdy) $display("FAIL dir%0d ready got %b want %b", i, rdy, exp_rdy); else passed++;
            total++; if (lat !== 2) $display("FAIL dir%0d latency got %0d want 2", i, lat); else passed++;
            total++; if (s !== es) $display("FAIL dir%0d res_s got %b want %b", i, s, es); else passed++;
            total++; if (o !== eo) $display("FAIL dir%0d res_o got %b want %b", i, o, eo); else passed++;
            total++; if (id !== 1'(g)) $display("FAIL dir%0d res_id got %b want %0d", i, id, g); else passed++;
            ptr_m = (g + 1) % N_REQ;
        end
    endtask

    task automatic test_random();
        logic [1:0] mask, sel, rdy, exp_rdy;
        logic [7:0] a, b;
        logic [3:0] s, es;
        logic       o, eo, id;
        int         g, lat;
        for (int i = 0; i < 20; i++) begin
            mask = 2'($urandom_range(1, 3));
            sel  = 2'($urandom);
            a    = 8'($urandom);
            b    = 8'($urandom);
            g    = pick_model(mask);
            exp_rdy = 2'b01 << g;
            model(sel[g], a[g*4 +: 4], b[g*4 +: 4], es, eo);
            run_op(mask, sel, a, b, rdy, s, o, id, lat);
            total++; if (rdy !== exp_rdy) $display("FAIL rnd%0d ready got %b want %b", i, rdy, exp_rdy); else passed++;
            total++; if (lat !== 2) $display("FAIL rnd%0d latency got %0d want 2", i, lat); else passed++;
            total++; if (s !== es) $display("FAIL rnd%0d res_s got %b want %b", i, s, es); else passed++;
            total++; if (o !== eo) $display("FAIL rnd%0d res_o got %b want %b", i, o, eo); else passed++;
            total++; if (id !== 1'(g)) $display("FAIL rnd%0d res_id got %b want %0d", i, id, g); else passed++;
            ptr_m = (g + 1) % N_REQ;
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] sel, exp_rdy;
        logic [7:0] a, b;
        logic [3:0] es;
        logic       eo;
        int         g, n;
        sel = 2'($urandom);
        a   = 8'($urandom);
        b   = 8'($urandom);
        g   = pick_model(2'b01);
        model(sel[g], a[g*4 +: 4], b[g*4 +: 4], es, eo);
        bus.req_valid = 2'b01;
        bus.req_sel   = sel;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n !== 1) $display("FAIL bp_latency got %0d want 1", n); else passed++;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({bus.res_valid, bus.res_s, bus.res_o, bus.res_id, bus.req_ready, bus.busy} !==
                {1'b1, es, eo, 1'(g), 2'b00, 1'b1})
                $display("FAIL bp_hold%0d got v=%b s=%b o=%b id=%b rdy=%b busy=%b want v=1 s=%b o=%b id=%0d rdy=00 busy=1",
                         c, bus.res_valid, bus.res_s, bus.res_o, bus.res_id, bus.req_ready, bus.busy, es, eo, g);
            else passed++;
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        ptr_m = (g + 1) % N_REQ;
        g = pick_model(2'b11);
        exp_rdy = 2'b01 << g;
        total++; if (bus.res_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", bus.res_valid); else passed++;
        total++; if (bus.req_ready !== exp_rdy) $display("FAIL bp_next_grant got %b want %b", bus.req_ready, exp_rdy); else passed++;
        model(sel[g], a[g*4 +: 4], b[g*4 +: 4], es, eo);
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (bus.res_id !== 1'(g)) $display("FAIL bp_next_id got %b want %0d", bus.res_id, g); else passed++;
        total++; if (bus.res_s !== es) $display("FAIL bp_next_s got %b want %b", bus.res_s, es); else passed++;
        @(posedge clk); #1;
        ptr_m = (g + 1) % N_REQ;
    endtask

    task automatic test_fairness();
        logic [1:0] sel;
        logic [7:0] a, b;
        logic [3:0] es;
        logic       eo;
        int         g, n;
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr_m = 0;
        sel = 2'($urandom);
        a   = 8'($urandom);
        b   = 8'($urandom);
        bus.req_sel   = sel;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.res_ready = 1'b1;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!bus.res_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            g = pick_model(2'b11);
            model(sel[g], a[g*4 +: 4], b[g*4 +: 4], es, eo);
            total++; if (n !== 2) $display("FAIL fair%0d cycles got %0d want 2", k, n); else passed++;
            total++; if (bus.res_id !== 1'(k % 2)) $display("FAIL fair%0d res_id got %b want %0d", k, bus.res_id, k % 2); else passed++;
            total++; if (bus.res_s !== es) $display("FAIL fair%0d res_s got %b want %b", k, bus.res_s, es); else passed++;
            total++; if (bus.res_o !== eo) $display("FAIL fair%0d res_o got %b want %b", k, bus.res_o, eo); else passed++;
            ptr_m = (g + 1) % N_REQ;
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] sel;
        logic [7:0] a, b;
        logic [3:0] es;
        logic       eo;
        int         n;
        sel = 2'($urandom);
        a   = 8'($urandom);
        b   = 8'($urandom);
        bus.req_sel   = sel;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.res_ready = 1'b1;
        bus.req_valid = 2'b10;
        @(posedge clk); #1;
        total++; if ({bus.busy, bus.res_valid} !== 2'b10) $display("FAIL rm_exec got busy=%b v=%b want busy=1 v=0", bus.busy, bus.res_valid); else passed++;
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ready, bus.res_valid, bus.busy, bus.res_s, bus.res_o, bus.res_id} !== 10'd0)
            $display("FAIL rm_async got rdy=%b v=%b busy=%b s=%h o=%b id=%b want all 0",
                     bus.req_ready, bus.res_valid, bus.busy, bus.res_s, bus.res_o, bus.res_id);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus.req_ready, bus.res_valid, bus.busy} !== 4'd0)
            $display("FAIL rm_held got rdy=%b v=%b busy=%b want all 0", bus.req_ready, bus.res_valid, bus.busy);
        else passed++;
        rst_n = 1'b1;
        bus.req_valid = '0;
        ptr_m = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if ({bus.res_valid, bus.busy} !== 2'b00) $display("FAIL rm_stale%0d got v=%b busy=%b want 0", c, bus.res_valid, bus.busy); else passed++;
        end
        bus.req_valid = 2'b11;
        #1;
        total++; if (bus.req_ready !== 2'b01) $display("FAIL rm_first_grant got %b want 01", bus.req_ready); else passed++;
        model(sel[0], a[3:0], b[3:0], es, eo);
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (bus.res_id !== 1'b0) $display("FAIL rm_id got %b want 0", bus.res_id); else passed++;
        total++; if (bus.res_s !== es) $display("FAIL rm_s got %b want %b", bus.res_s, es); else passed++;
        total++; if (bus.res_o !== eo) $display("FAIL rm_o got %b want %b", bus.res_o, eo); else passed++;
        @(posedge clk); #1;
        ptr_m = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", total);
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_sel   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
